// File: rtl/instruction_decode.sv
// instruction_decode: decode stage of the 8-bit pipelined processor.
//
// Holds the 4x8 register file, resolves branches back to fetch, squashes the
// two wrong-path slots after a taken branch, and registers the ID/EX bundle.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst            - asynchronous active-high reset
//   instruction    - fetched word: [7:4] opcode, [3:2] rd, [1:0] rs
//   pc_next        - address of instruction + 1
//   wb_en/addr/data- register file writeback (bypassed to same-cycle reads)
//   branch_taken   - one-cycle pulse to fetch, with branch_address
//   id_*           - registered ID/EX bundle
//   illegal        - one-cycle pulse on a reserved opcode
module instruction_decode (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instruction,
  input  logic [7:0] pc_next,
  input  logic       wb_en,
  input  logic [1:0] wb_addr,
  input  logic [7:0] wb_data,
  output logic       branch_taken,
  output logic [7:0] branch_address,
  output logic       id_valid,
  output logic [3:0] id_opcode,
  output logic [1:0] id_rd,
  output logic [7:0] id_op_a,
  output logic [7:0] id_op_b,
  output logic       id_reg_write,
  output logic [7:0] id_pc_next,
  output logic       illegal
);

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpXor  = 4'h5;
  localparam logic [3:0] OpMov  = 4'h6;
  localparam logic [3:0] OpNot  = 4'h7;
  localparam logic [3:0] OpShl  = 4'h8;
  localparam logic [3:0] OpLi   = 4'h9;
  localparam logic [3:0] OpRsvA = 4'hA;
  localparam logic [3:0] OpRsvB = 4'hB;
  localparam logic [3:0] OpBrz  = 4'hC;
  localparam logic [3:0] OpBrnz = 4'hD;
  localparam logic [3:0] OpJr   = 4'hE;
  localparam logic [3:0] OpJrel = 4'hF;

  typedef enum logic [1:0] {StRun, StSkip2, StSkip1} state_e;

  state_e     state_q;
  logic [7:0] rf_q [4];

  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] rd_val;
  logic [7:0] rs_val;
  logic [7:0] jrel_target;

  assign opcode = instruction[7:4];
  assign rd     = instruction[3:2];
  assign rs     = instruction[1:0];

  // Same-cycle writeback wins over the array contents.
  assign rd_val = (wb_en && (wb_addr == rd)) ? wb_data : rf_q[rd];
  assign rs_val = (wb_en && (wb_addr == rs)) ? wb_data : rf_q[rs];

  // {rd,rs} is a signed 4-bit offset; the add wraps modulo 256.
  assign jrel_target = pc_next + {{4{instruction[3]}}, instruction[3:0]};

  logic       valid_d;
  logic [3:0] opcode_d;
  logic [7:0] op_a_d;
  logic [7:0] op_b_d;
  logic       reg_write_d;
  logic       illegal_d;
  logic       taken_d;
  logic [7:0] target_d;

  always_comb begin
    valid_d     = 1'b0;
    opcode_d    = 4'h0;
    op_a_d      = 8'h00;
    op_b_d      = 8'h00;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    taken_d     = 1'b0;
    target_d    = 8'h00;
    if (state_q == StRun) begin
      valid_d  = 1'b1;
      opcode_d = opcode;
      case (opcode)
        OpNop: ;
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl: begin
          op_a_d      = rd_val;
          op_b_d      = rs_val;
          reg_write_d = 1'b1;
        end
        OpMov: begin
          op_b_d      = rs_val;
          reg_write_d = 1'b1;
        end
        OpNot: begin
          op_a_d      = rd_val;
          reg_write_d = 1'b1;
        end
        OpLi: begin
          op_b_d      = {6'b0, rs};
          reg_write_d = 1'b1;
        end
        OpRsvA, OpRsvB: begin
          // Issued downstream as a plain NOP.
          opcode_d  = OpNop;
          illegal_d = 1'b1;
        end
        OpBrz, OpBrnz, OpJr: begin
          op_a_d   = rd_val;
          op_b_d   = rs_val;
          target_d = rs_val;
          case (opcode)
            OpBrz:   taken_d = (rd_val == 8'h00);
            OpBrnz:  taken_d = (rd_val != 8'h00);
            default: taken_d = 1'b1;
          endcase
        end
        OpJrel: begin
          op_a_d   = rd_val;
          op_b_d   = rs_val;
          target_d = jrel_target;
          taken_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Squash FSM and registered ID/EX bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StSkip1;
      branch_taken   <= 1'b0;
      branch_address <= 8'h00;
      id_valid       <= 1'b0;
      id_opcode      <= 4'h0;
      id_rd          <= 2'd0;
      id_op_a        <= 8'h00;
      id_op_b        <= 8'h00;
      id_reg_write   <= 1'b0;
      id_pc_next     <= 8'h00;
      illegal        <= 1'b0;
    end else begin
      case (state_q)
        StRun:   state_q <= taken_d ? StSkip2 : StRun;
        StSkip2: state_q <= StSkip1;
        default: state_q <= StRun;
      endcase
      branch_taken   <= taken_d;
      branch_address <= taken_d ? target_d : 8'h00;
      id_valid       <= valid_d;
      id_opcode      <= opcode_d;
      id_rd          <= valid_d ? rd : 2'd0;
      id_op_a        <= op_a_d;
      id_op_b        <= op_b_d;
      id_reg_write   <= reg_write_d;
      id_pc_next     <= valid_d ? pc_next : 8'h00;
      illegal        <= illegal_d;
    end
  end

  // Register file: writes happen regardless of squash state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage of the 8-bit pipelined processor. Consumes the fetch stage's registered `instruction`/`pc_next` pair and holds the 4×8 register file. It resolves branches, returning `branch_taken`/`branch_address` to fetch, and squashes wrong-path slots. It presents a registered ID/EX bundle to execute.

## Interface
Parameters:
- None; widths fixed: 8-bit datapath, 4 registers.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset. Must be held across at least one rising `clk`.
- `instruction` in 8: fetched instruction. Fields: [7:4] opcode, [3:2] rd, [1:0] rs.
- `pc_next` in 8: address of `instruction` + 1, aligned with `instruction`.
- `wb_en` in 1: writeback strobe.
- `wb_addr` in 2: writeback register.
- `wb_data` in 8: writeback value.
- `branch_taken` out 1: registered one-cycle pulse to fetch.
- `branch_address` out 8: registered target; valid while `branch_taken`=1.
- `id_valid` out 1: ID/EX bundle holds a real instruction.
- `id_opcode` out 4: opcode.
- `id_rd` out 2: destination register.
- `id_op_a` out 8: operand A.
- `id_op_b` out 8: operand B.
- `id_reg_write` out 1: execute result is to be written to `id_rd`.
- `id_pc_next` out 8: `pc_next` of the issued instruction.
- `illegal` out 1: registered pulse on a reserved opcode.

## Operation
- Register file: R0–R3, all reset to 0.
  - Written on the edge when `wb_en`=1; the write occurs in every state.
  - Reads bypass: if `wb_en`=1 and `wb_addr` matches the read address, the read returns `wb_data`.
- Hazards from in-flight EX results are not handled here; forwarding uses `id_rd`/`id_reg_write` downstream.
- Opcode handling:
  - 0x0 NOP: `id_valid`=1, no write.
  - 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR, 0x5 XOR: op_a=R[rd], op_b=R[rs], reg_write=1.
  - 0x6 MOV: op_b=R[rs], reg_write=1.
  - 0x7 NOT: op_a=R[rd], reg_write=1.
  - 0x8 SHL: op_a=R[rd], op_b=R[rs], reg_write=1.
  - 0x9 LI: op_b={6'b0, rs}, reg_write=1.
  - 0xA, 0xB reserved: issued as NOP with `illegal`=1.
  - 0xC BRZ: taken if R[rd]==0; target R[rs].
  - 0xD BRNZ: taken if R[rd]!=0; target R[rs].
  - 0xE JR: always taken; target R[rs].
  - 0xF JREL: always taken; target = `pc_next` + sign-extended {rd,rs}, modulo 256 (wraps).
- Branch opcodes issue with `id_valid`=1 and `id_reg_write`=0. op_a/op_b carry the read values.
- Squash FSM states: RUN, SKIP2, SKIP1.
  - Reset → SKIP1. This drops the duplicated word-0 slot fetch presents after reset.
  - RUN and a taken branch → SKIP2.
  - RUN and no taken branch → RUN.
  - SKIP2 → SKIP1 → RUN unconditionally.
- In SKIP1/SKIP2 the input is ignored. All `id_*` outputs are 0, and `branch_taken` and `illegal` are 0.
- A branch in a skipped slot is never evaluated.

## Timing
- Reset values: every output is 0, the FSM is in SKIP1, and R0–R3 are 0.
- A reset asserted mid-operation aborts any pending squash and re-enters SKIP1 immediately, asynchronously.
- Decode latency is 1 cycle: an instruction presented in cycle n appears on `id_*` in cycle n+1.
- Branch sequence:
  - Branch resolves in cycle n; `branch_taken`=1 with `branch_address` in cycle n+1.
  - Slots n+1 and n+2 are squashed.
  - The target instruction arrives and is decoded in cycle n+3.
- `branch_taken` is high for exactly one cycle per taken branch. Back-to-back taken pulses are impossible: minimum spacing is 3 cycles.
- Register write and bypass:
  - A write in cycle n is visible through the bypass in cycle n.
  - From cycle n+1 it is read from the array.
- A writeback and a branch-condition read of the same register in the same cycle use `wb_data`.

## Test plan
- Reset held 2 edges, then a stream of NOPs:
  - The first post-reset slot is squashed (`id_valid`=0).
  - Subsequent slots give `id_valid`=1.
  - All outputs are 0 during reset.
- Write R1=0x05 and R2=0x03 via `wb_*`, then present ADD R1,R2 (0x16):
  - Next cycle `id_op_a`=0x05, `id_op_b`=0x03, `id_rd`=1, `id_reg_write`=1.
- With R2=0x40, present JR R2 (0xE2):
  - Next cycle `branch_taken`=1 and `branch_address`=0x40.
  - Two following slots have `id_valid`=0; the third is decoded.
- JREL 0xF8 (offset −8) at `pc_next`=0x03 → `branch_address`=0xFB (wrap).
  - JREL 0xF7 at `pc_next`=0xFE → `branch_address`=0x05.
- BRZ R0,R1 (0xC1) with R0=0x00 → taken.
  - Repeat with `wb_en`=1, `wb_addr`=0, `wb_data`=0x01 in the same cycle → not taken (bypass).
- Reserved opcode 0xA0 → `illegal` pulses 1 cycle, with `id_valid`=1 and `id_reg_write`=0.
  - Assert `rst` while in SKIP2 → outputs clear and the FSM returns to SKIP1.
